mem_stage: RTL and testbench

- Memory-access stage sitting directly downstream of the EX/MEM pipeline register and feeding the write-back stage.
- Consumes the EX/MEM data and control outputs and drives a multi-cycle, handshaked data memory.
- Holds the upstream EX/MEM register via `stall` until the access completes.
- Registers the result (the MEM/WB boundary) for write-back.

---
 rtl/mem_stage.sv | 137 +++++++++++++
 tb/tb_mem_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Data-memory access stage: issues handshaked loads/stores and registers the MEM/WB result.
// Latency 1 cycle for non-memory ops, memory latency + 1 for accesses; holds EX/MEM via stall while busy.
module mem_stage #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] write_data_in,
  input  logic [DATA_W-1:0] pc_plus_two_in,
  input  logic [7:0]        mem_ctrl_in,
  input  logic [7:0]        wb_ctrl_in,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] rd_data_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] pc_plus_two_out,
  output logic [7:0]        wb_ctrl_out,
  output logic              err
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            state_q;
  logic [7:0]        cnt_q, cnt_d;
  logic              kill_q, req_q, wr_q, err_q;
  logic [DATA_W-1:0] addr_q, wdata_q, rd_q, alu_q, pc_q, snap_pc_q;
  logic [7:0]        wb_q, snap_wb_q;
  logic              mem_op, issue, timeout;
  logic              unused_ctrl;

  assign unused_ctrl = ^mem_ctrl_in[7:2];
  assign mem_op      = mem_ctrl_in[0] | mem_ctrl_in[1];
  assign issue       = (state_q == IDLE) && mem_op && !flush && !alu_in[0];
  assign cnt_d       = cnt_q + 8'd1;
  // cnt_d counts this cycle too, so the request lives at most TIMEOUT busy cycles
  assign timeout     = (state_q == BUSY) && !mem_ack && (cnt_d == TIMEOUT_C);
  assign stall       = rst && (issue || ((state_q == BUSY) && !mem_ack && !timeout));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      kill_q    <= 1'b0;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      alu_q     <= '0;
      pc_q      <= '0;
      wb_q      <= '0;
      snap_pc_q <= '0;
      snap_wb_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush || !mem_op) begin
            alu_q <= alu_in;
            pc_q  <= pc_plus_two_in;
            rd_q  <= '0;
            wb_q  <= flush ? 8'h00 : wb_ctrl_in;
          end else if (alu_in[0]) begin
            alu_q <= '0;
            pc_q  <= '0;
            rd_q  <= '0;
            wb_q  <= '0;
            err_q <= 1'b1;
          end else begin
            req_q     <= 1'b1;
            wr_q      <= mem_ctrl_in[1];
            addr_q    <= alu_in;
            wdata_q   <= write_data_in;
            cnt_q     <= '0;
            kill_q    <= 1'b0;
            snap_pc_q <= pc_plus_two_in;
            snap_wb_q <= wb_ctrl_in;
            alu_q     <= '0;
            pc_q      <= '0;
            rd_q      <= '0;
            wb_q      <= '0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            kill_q  <= 1'b0;
            rd_q    <= wr_q ? '0 : mem_rdata;
            alu_q   <= addr_q;
            pc_q    <= snap_pc_q;
            // a flush arriving with the ack still squashes the held instruction
            wb_q    <= (kill_q || flush) ? 8'h00 : snap_wb_q;
            state_q <= IDLE;
          end else if (timeout) begin
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            kill_q  <= 1'b0;
            alu_q   <= '0;
            pc_q    <= '0;
            rd_q    <= '0;
            wb_q    <= '0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
            if (flush) kill_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign mem_req         = req_q;
  assign mem_wr          = wr_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign rd_data_out     = rd_q;
  assign alu_out         = alu_q;
  assign pc_plus_two_out = pc_q;
  assign wb_ctrl_out     = wb_q;
  assign err             = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: instruction-level model drives expectations, one compare process checks each cycle.
module tb_mem_stage;
  localparam int W  = 16;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst, flush, mem_ack;
  logic [W-1:0] alu_in, write_data_in, pc_plus_two_in, mem_rdata;
  logic [7:0]   mem_ctrl_in, wb_ctrl_in;
  logic         stall, mem_req, mem_wr, err;
  logic [W-1:0] mem_addr, mem_wdata, rd_data_out, alu_out, pc_plus_two_out;
  logic [7:0]   wb_ctrl_out;

  mem_stage #(.DATA_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .flush(flush), .alu_in(alu_in),
    .write_data_in(write_data_in), .pc_plus_two_in(pc_plus_two_in),
    .mem_ctrl_in(mem_ctrl_in), .wb_ctrl_in(wb_ctrl_in), .stall(stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rd_data_out(rd_data_out),
    .alu_out(alu_out), .pc_plus_two_out(pc_plus_two_out), .wb_ctrl_out(wb_ctrl_out),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int stall_cnt = 0, req_cnt = 0, wr_cnt = 0;

  bit           chk_en = 1'b0;
  logic         exp_stall, exp_req, exp_wr, exp_err, exp_bub;
  logic [W-1:0] exp_addr, exp_wdata, exp_alu, exp_pc, exp_rd;
  logic [7:0]   exp_wb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A bubble only promises wb_ctrl_out = 0; the other MEM/WB fields are don't-care.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      chk("mem_wr", 32'(mem_wr), 32'(exp_wr));
      if (exp_req) begin
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
      end
      chk("wb_ctrl_out", 32'(wb_ctrl_out), 32'(exp_wb));
      if (!exp_bub) begin
        chk("alu_out", 32'(alu_out), 32'(exp_alu));
        chk("pc_plus_two_out", 32'(pc_plus_two_out), 32'(exp_pc));
        chk("rd_data_out", 32'(rd_data_out), 32'(exp_rd));
      end
      chk("err", 32'(err), 32'(exp_err));
      if (stall === 1'b1)   stall_cnt++;
      if (mem_req === 1'b1) req_cnt++;
      if (mem_wr === 1'b1)  wr_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mwb(input logic [W-1:0] a, input logic [W-1:0] p, input logic [W-1:0] r,
                         input logic [7:0] w);
    exp_bub = 1'b0; exp_alu = a; exp_pc = p; exp_rd = r; exp_wb = w;
  endtask

  task automatic bubble();
    exp_bub = 1'b1; exp_wb = 8'h00;
  endtask

  task automatic clear_exp();
    exp_stall = 0; exp_req = 0; exp_wr = 0; exp_err = 0; exp_addr = '0; exp_wdata = '0;
    set_mwb('0, '0, '0, 8'h00);
  endtask

  // Non-memory op (reserved ctrl bits set): always a one-cycle pass-through.
  task automatic do_alu(input logic [W-1:0] a, input logic [W-1:0] p, input logic [7:0] w,
                        input logic fl, input logic spur);
    alu_in = a; pc_plus_two_in = p; wb_ctrl_in = w; mem_ctrl_in = 8'hFC;
    write_data_in = 16'hDEAD; flush = fl; mem_ack = spur; mem_rdata = 16'hFFFF;
    exp_stall = 0;
    step();
    mem_ack = 0; flush = 0;
    set_mwb(a, p, '0, fl ? 8'h00 : w);
    exp_req = 0; exp_wr = 0;
  endtask

  // Memory op. lat = busy cycles before the ack (-1: never acked); fl_at = cycle flush is raised
  // (0: same cycle the op is presented, -1: never).
  task automatic do_mem(input logic st, input logic [W-1:0] a, input logic [W-1:0] wd,
                        input logic [W-1:0] p, input logic [7:0] w, input int lat,
                        input logic [W-1:0] rd, input int fl_at);
    logic ack_c, to_c, killed;
    alu_in = a; write_data_in = wd; pc_plus_two_in = p; wb_ctrl_in = w;
    mem_ctrl_in = st ? 8'h03 : 8'h01; mem_ack = 0; flush = (fl_at == 0);
    if (fl_at == 0) begin
      exp_stall = 0;
      step();
      flush = 0;
      set_mwb(a, p, '0, 8'h00);
    end else if (a[0]) begin
      exp_stall = 0;
      step();
      bubble(); exp_err = 1;
    end else begin
      exp_stall = 1;
      step();
      exp_req = 1; exp_wr = st; exp_addr = a; exp_wdata = wd; bubble();
      killed = 0;
      for (int k = 1; k <= 300; k++) begin
        ack_c = (lat >= 0) && (k == lat + 1);
        to_c  = !ack_c && (k == TO);
        if (k == fl_at) begin flush = 1; killed = 1; end
        mem_ack = ack_c; mem_rdata = ack_c ? rd : 16'h5A5A;
        exp_stall = !(ack_c || to_c);
        step();
        mem_ack = 0; flush = 0;
        if (ack_c) begin
          exp_req = 0; exp_wr = 0;
          set_mwb(a, p, st ? '0 : rd, killed ? 8'h00 : w);
          break;
        end
        if (to_c) begin
          exp_req = 0; exp_wr = 0; bubble(); exp_err = 1;
          break;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; flush = 0; mem_ack = 0; alu_in = '0; write_data_in = '0; pc_plus_two_in = '0;
    mem_rdata = '0; mem_ctrl_in = '0; wb_ctrl_in = '0;
    clear_exp();
    #12;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_alu_out", 32'(alu_out), 32'h0);
    chk("rst_wb", 32'(wb_ctrl_out), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    step();
    rst = 1;
    chk_en = 1;

    stall_cnt = 0;
    do_alu(16'h1234, 16'h0010, 8'h05, 1'b0, 1'b0);
    chk("alu_lit_alu", 32'(alu_out), 32'h1234);
    chk("alu_lit_wb", 32'(wb_ctrl_out), 32'h05);
    chk("alu_no_stall", 32'(stall_cnt), 32'd0);

    stall_cnt = 0;
    do_mem(1'b0, 16'h0040, 16'h0000, 16'h0012, 8'h09, 3, 16'hBEEF, -1);
    chk("load_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("load_lit_rd", 32'(rd_data_out), 32'hBEEF);
    chk("load_lit_wb", 32'(wb_ctrl_out), 32'h09);
    chk("load_lit_alu", 32'(alu_out), 32'h0040);

    wr_cnt = 0;
    do_mem(1'b1, 16'h0100, 16'hA5A5, 16'h0014, 8'h0A, 0, 16'h7777, -1);
    chk("store_lit_rd", 32'(rd_data_out), 32'h0);
    chk("store_lit_wb", 32'(wb_ctrl_out), 32'h0A);
    do_alu(16'h0222, 16'h0016, 8'h03, 1'b0, 1'b0);
    chk("b2b_alu", 32'(alu_out), 32'h0222);
    chk("store_wr_cycles", 32'(wr_cnt), 32'd1);

    do_alu(16'h0333, 16'h0018, 8'h04, 1'b0, 1'b1);
    chk("spurious_ack_rd", 32'(rd_data_out), 32'h0);

    do_alu(16'h0444, 16'h001A, 8'h06, 1'b1, 1'b0);
    chk("flush_idle_wb", 32'(wb_ctrl_out), 32'h00);

    req_cnt = 0;
    do_mem(1'b0, 16'h0050, 16'h0000, 16'h001C, 8'h0B, 0, 16'h0000, 0);
    chk("flush_memop_noreq", 32'(req_cnt), 32'd0);

    do_mem(1'b0, 16'h0060, 16'h0000, 16'h001E, 8'h0C, 2, 16'h1111, 1);
    chk("flush_busy_wb", 32'(wb_ctrl_out), 32'h00);
    do_alu(16'h0555, 16'h0020, 8'h07, 1'b0, 1'b0);
    chk("after_flush_wb", 32'(wb_ctrl_out), 32'h07);

    req_cnt = 0; stall_cnt = 0;
    do_mem(1'b0, 16'h0080, 16'h0000, 16'h0022, 8'h0D, -1, 16'h0000, -1);
    chk("timeout_req_cycles", 32'(req_cnt), 32'd4);
    chk("timeout_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("timeout_err", 32'(err), 32'h1);
    do_alu(16'h0666, 16'h0024, 8'h08, 1'b0, 1'b0);

    // load left in flight, then reset between clock edges
    alu_in = 16'h0090; write_data_in = '0; pc_plus_two_in = 16'h0026; wb_ctrl_in = 8'h0E;
    mem_ctrl_in = 8'h01; flush = 0; mem_ack = 0;
    exp_stall = 1;
    step();
    exp_req = 1; exp_wr = 0; exp_addr = 16'h0090; exp_wdata = '0; bubble();
    step();
    #2;
    chk("req_before_rst", 32'(mem_req), 32'h1);
    chk_en = 0;
    rst = 0;
    #1;
    chk("rst_busy_req", 32'(mem_req), 32'h0);
    chk("rst_busy_addr", 32'(mem_addr), 32'h0);
    chk("rst_busy_stall", 32'(stall), 32'h0);
    chk("rst_busy_err", 32'(err), 32'h0);
    chk("rst_busy_pc", 32'(pc_plus_two_out), 32'h0);
    mem_ctrl_in = 8'h00;
    step();
    rst = 1;
    clear_exp();
    chk_en = 1;

    req_cnt = 0;
    do_mem(1'b0, 16'h0041, 16'h0000, 16'h0030, 8'h0F, 3, 16'h0000, -1);
    chk("unaligned_noreq", 32'(req_cnt), 32'd0);
    chk("unaligned_err", 32'(err), 32'h1);
    chk("unaligned_wb", 32'(wb_ctrl_out), 32'h00);
    do_alu(16'h0777, 16'h0032, 8'h11, 1'b0, 1'b0);
    do_alu(16'h0888, 16'h0034, 8'h12, 1'b0, 1'b0);
    chk("err_sticky", 32'(err), 32'h1);

    #2;
    chk_en = 0;
    rst = 0;
    #1;
    chk("err_cleared", 32'(err), 32'h0);
    step();
    rst = 1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
